prf_free_queue: RTL and testbench
=================================

# prf_free_queue

Parametrised physical-register free list with speculative allocation and flush recovery for the renamed RV32I pipeline. It supplies destination tags to rename in decode and accepts tags released at commit. Unlike a simple free list, it keeps separate speculative and committed head pointers, so a pipeline flush restores the allocation state in one cycle. It sits between the rename unit, the commit/writeback logic and the PRF.

## Interface

- NUM_PHYS, 64: physical registers; TAG_W = $clog2(NUM_PHYS)
- NUM_ARCH, 32: architectural registers; tags 0..NUM_ARCH-1 are mapped at reset and never enter the queue initially
- DEPTH (localparam) = NUM_PHYS - NUM_ARCH; CNT_W = $clog2(DEPTH+1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_req  in  1  rename wants a destination tag this cycle
- alloc_valid  out  1  a speculative tag is available (free_count != 0)
- alloc_phys  out  TAG_W  tag at the speculative head; valid when alloc_valid
- commit_en  in  1  a tag-allocating instruction committed; advances the committed head
- free_en  in  1  return free_phys to the queue (the old mapping of a committing instruction)
- free_phys  in  TAG_W  tag being released
- flush  in  1  squash every speculative allocation
- free_count  out  CNT_W  entries available for speculative allocation
- dbg_err  out  1  sticky protocol-error flag (see Configuration)

## Operation

- Storage: circular array of DEPTH entries of TAG_W bits. Pointers spec_head, commit_head and tail are each log2(DEPTH) bits plus a wrap bit.
- Derived counts:
  - free_count = tail - spec_head (wrap-aware)
  - committed occupancy = tail - commit_head; it never exceeds DEPTH
- Alloc: alloc_req && alloc_valid && !flush advances spec_head by one, with wrap.
- Commit: commit_en advances commit_head by one.
  - commit_en while commit_head == spec_head is illegal. It is ignored, and sets dbg_err when checking is compiled in.
- Free: free_en writes free_phys at tail and advances tail.
  - Free is applied regardless of flush.
  - A free when committed occupancy == DEPTH is illegal. It is dropped, and sets dbg_err when checking is compiled in.
- Flush: spec_head <= commit_head after this cycle's commit is applied; the flush target includes a same-cycle commit_en.
  - An alloc in the same cycle as flush is ignored.
- Simultaneous alloc + free when free_count == 0: the alloc is refused. alloc_valid reflects the pre-edge state, and there is no bypass from free to alloc.
- Simultaneous alloc + free when free_count > 0: both apply; free_count is unchanged.
- Tag 0 (x0) is never allocated, because rename does not request a tag for rd = x0. This block does not special-case tag 0.

## Timing

- Reset state:
  - entry[i] = NUM_ARCH + i
  - spec_head = commit_head = 0
  - tail = 0 with the wrap bit set (queue full)
  - outputs: alloc_valid = 1, alloc_phys = NUM_ARCH, free_count = DEPTH, dbg_err = 0
- rst mid-operation discards all state, including pending frees, and returns to the reset state at the next edge.
- alloc_phys and alloc_valid are combinational from registered state; there is no input-to-output combinational path.
- Pointer updates take effect on the same edge as the request.
  - The next tag appears on alloc_phys one cycle after an accepted alloc.
  - A freed tag is allocatable one cycle after free_en at the earliest, and only once spec_head reaches it.
- Flush latency: one edge. In the cycle after flush, free_count equals committed occupancy.
- Wrap-around: each pointer wraps from DEPTH-1 to 0 and toggles its wrap bit. The equal-index case is full or empty depending on the wrap-bit comparison.

## Configuration

- FREE_LIST_CHECK_EN defined:
  - Keep a NUM_PHYS-bit free bitmap.
  - A free of a tag already marked free (double free) is dropped and sets dbg_err.
  - Illegal commit and overflow free are dropped and set dbg_err.
  - dbg_err clears only on rst.
- FREE_LIST_CHECK_EN not defined:
  - No bitmap; dbg_err is tied 0.
  - Illegal commit and overflow free are still dropped, but are not flagged.
  - All other frees are pushed unconditionally.

## Test plan

- Reset, then 32 back-to-back allocs (NUM_PHYS=64) -> alloc_phys sequence 32..63. After the 32nd, alloc_valid=0 and free_count=0; a 33rd alloc_req is ignored.
- 5 allocs (32..36), 2 commits, then flush -> next cycle free_count=30 and alloc_phys=34.
- Empty queue; alloc_req + free_en(free_phys=7) in the same cycle -> alloc refused. Next cycle alloc_valid=1, alloc_phys=7, free_count=1.
- Run 100 alloc/commit/free triples, freeing tags 1..100 mod 32 -> pointers wrap cleanly and alloc order equals free order; free_count stays at 31 after the first triple.
- With FREE_LIST_CHECK_EN defined: free_phys=40 twice without allocating it -> second free dropped and dbg_err=1. After rst, dbg_err=0.
- Flush + commit_en + free_en(9) in the same cycle after 3 allocs -> spec_head = commit_head+1, and tag 9 is queued at tail.

Source files
------------

// File: rtl/prf_free_queue_if.sv
// prf_free_queue_if: bundle between the rename/commit side (master) and the physical-register
// free queue (slave).
//   alloc_req   master->slave  rename wants a destination tag this cycle
//   alloc_valid slave->master  a speculative tag is available
//   alloc_phys  slave->master  tag at the speculative head
//   commit_en   master->slave  a tag-allocating instruction committed
//   free_en     master->slave  return free_phys to the queue
//   free_phys   master->slave  tag being released
//   flush       master->slave  squash every speculative allocation
//   free_count  slave->master  entries available for speculative allocation
//   dbg_err     slave->master  sticky protocol-error flag
interface prf_free_queue_if #(
  parameter int unsigned NUM_PHYS = 64,
  parameter int unsigned NUM_ARCH = 32
);
  localparam int unsigned TAG_W = $clog2(NUM_PHYS);
  localparam int unsigned DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             alloc_req;
  logic             alloc_valid;
  logic [TAG_W-1:0] alloc_phys;
  logic             commit_en;
  logic             free_en;
  logic [TAG_W-1:0] free_phys;
  logic             flush;
  logic [CNT_W-1:0] free_count;
  logic             dbg_err;

  modport master (
    output alloc_req, commit_en, free_en, free_phys, flush,
    input  alloc_valid, alloc_phys, free_count, dbg_err
  );

  modport slave (
    input  alloc_req, commit_en, free_en, free_phys, flush,
    output alloc_valid, alloc_phys, free_count, dbg_err
  );
endinterface

// File: rtl/prf_free_queue.sv
// prf_free_queue: physical-register free list with a speculative head (rename allocations) and
// a committed head (retired allocations). A flush copies the committed head into the
// speculative head, so recovery takes a single edge.
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  prf_free_queue_if.slave (alloc/commit/free/flush handshake, free_count, dbg_err)
// Optional feature: define FREE_LIST_CHECK_EN to add a free bitmap with double-free
// detection and a sticky dbg_err flag; without it dbg_err is tied 0.
module prf_free_queue #(
  parameter int unsigned NUM_PHYS = 64,
  parameter int unsigned NUM_ARCH = 32
) (
  input logic             clk,
  input logic             rst,
  prf_free_queue_if.slave bus
);
  localparam int unsigned TAG_W = $clog2(NUM_PHYS);
  localparam int unsigned DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W = IDX_W + 1;

  // Pointer = {wrap, index}; explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1)) begin
      r = {~p[IDX_W], {IDX_W{1'b0}}};
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  // Number of entries from b up to (not including) a.
  function automatic logic [CNT_W-1:0] ptr_diff(input logic [PTR_W-1:0] a,
                                                 input logic [PTR_W-1:0] b);
    logic [CNT_W-1:0] ai;
    logic [CNT_W-1:0] bi;
    ai = CNT_W'(a[IDX_W-1:0]);
    bi = CNT_W'(b[IDX_W-1:0]);
    if (a[IDX_W] == b[IDX_W]) begin
      return ai - bi;
    end
    return CNT_W'(DEPTH) - bi + ai;
  endfunction

  logic [TAG_W-1:0] entries_q [DEPTH];
  logic [PTR_W-1:0] spec_head_q, spec_head_d;
  logic [PTR_W-1:0] commit_head_q, commit_head_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic [CNT_W-1:0] free_cnt;
  logic             can_alloc;
  logic             commit_ok;
  logic             free_room;
  logic             free_ok;

  always_comb begin
    free_cnt  = ptr_diff(tail_q, spec_head_q);
    can_alloc = (free_cnt != '0);
    // Commit may only retire tags that rename has actually handed out.
    commit_ok     = bus.commit_en && (commit_head_q != spec_head_q);
    commit_head_d = commit_ok ? ptr_inc(commit_head_q) : commit_head_q;
    // A same-cycle commit makes room for the old mapping it releases.
    free_room = (ptr_diff(tail_q, commit_head_d) != CNT_W'(DEPTH));
  end

`ifdef FREE_LIST_CHECK_EN
  // Bit set while a tag sits between commit_head and tail (committed-free).
  logic [NUM_PHYS-1:0] bitmap_q, bitmap_d;
  logic [TAG_W-1:0]    commit_tag;
  logic                dbl_free;
  logic                proto_err;
  logic                dbg_err_q;

  always_comb begin
    commit_tag = entries_q[commit_head_q[IDX_W-1:0]];
    dbl_free   = bitmap_q[bus.free_phys] && !(commit_ok && (commit_tag == bus.free_phys));
    free_ok    = bus.free_en && free_room && !dbl_free;
    proto_err  = (bus.commit_en && !commit_ok) || (bus.free_en && !free_ok);
    bitmap_d   = bitmap_q;
    if (commit_ok) bitmap_d[commit_tag] = 1'b0;
    if (free_ok)   bitmap_d[bus.free_phys] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PHYS; i++) begin
        bitmap_q[i] <= (i >= NUM_ARCH);
      end
      dbg_err_q <= 1'b0;
    end else begin
      bitmap_q  <= bitmap_d;
      dbg_err_q <= dbg_err_q | proto_err;
    end
  end

  assign bus.dbg_err = dbg_err_q;
`else
  always_comb begin
    free_ok = bus.free_en && free_room;
  end

  assign bus.dbg_err = 1'b0;
`endif

  always_comb begin
    tail_d = free_ok ? ptr_inc(tail_q) : tail_q;
    // Flush wins over a same-cycle alloc; alloc_valid is pre-edge, so no free->alloc bypass.
    if (bus.flush) begin
      spec_head_d = commit_head_d;
    end else if (bus.alloc_req && can_alloc) begin
      spec_head_d = ptr_inc(spec_head_q);
    end else begin
      spec_head_d = spec_head_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= {1'b1, {IDX_W{1'b0}}};
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= TAG_W'(NUM_ARCH + i);
      end
    end else begin
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      if (free_ok) entries_q[tail_q[IDX_W-1:0]] <= bus.free_phys;
    end
  end

  assign bus.alloc_valid = can_alloc;
  assign bus.alloc_phys  = entries_q[spec_head_q[IDX_W-1:0]];
  assign bus.free_count  = free_cnt;

endmodule

// File: tb/tb_prf_free_queue.sv
// tb_prf_free_queue: self-checking bench for prf_free_queue (NUM_PHYS=64, NUM_ARCH=32).
// The reference model is an ordered list of committed-free tags plus a count of how many of
// them rename has speculatively taken.
module tb_prf_free_queue;
  localparam int unsigned NUM_PHYS = 64;
  localparam int unsigned NUM_ARCH = 32;
  localparam int unsigned DEPTH    = NUM_PHYS - NUM_ARCH;
`ifdef FREE_LIST_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  prf_free_queue_if #(.NUM_PHYS(NUM_PHYS), .NUM_ARCH(NUM_ARCH)) bus_if ();

  prf_free_queue #(.NUM_PHYS(NUM_PHYS), .NUM_ARCH(NUM_ARCH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model.
  logic [5:0] m_q [$];
  int         spec_n;
  bit         m_err;

  task automatic model_reset();
    m_q = {};
    for (int i = 0; i < int'(DEPTH); i++) m_q.push_back(6'(NUM_ARCH + i));
    spec_n = 0;
    m_err  = 1'b0;
  endtask

  task automatic model_step(input bit a, input bit c, input bit f, input logic [5:0] t,
                            input bit fl, input bit r);
    bit         a_ok;
    bit         dup;
    logic [5:0] junk;
    if (r) begin
      model_reset();
      return;
    end
    a_ok = a && !fl && (spec_n < m_q.size());
    if (c) begin
      if (spec_n > 0) begin
        junk = m_q.pop_front();
        spec_n--;
      end else if (CHECK) begin
        m_err = 1'b1;
      end
    end
    dup = 1'b0;
    if (CHECK) foreach (m_q[i]) if (m_q[i] == t) dup = 1'b1;
    if (f) begin
      if ((m_q.size() < DEPTH) && !dup) m_q.push_back(t);
      else if (CHECK) m_err = 1'b1;
    end
    if (fl) spec_n = 0;
    else if (a_ok) spec_n++;
  endtask

  function automatic bit exp_valid();
    return spec_n < m_q.size();
  endfunction

  function automatic int exp_count();
    return m_q.size() - spec_n;
  endfunction

  function automatic logic [5:0] exp_phys();
    return (spec_n < m_q.size()) ? m_q[spec_n] : 6'd0;
  endfunction

  // Drive one cycle of inputs, clock it, and advance the model.
  task automatic tick(input bit a, input bit c, input bit f, input logic [5:0] t,
                      input bit fl, input bit r);
    bus_if.alloc_req = a;
    bus_if.commit_en = c;
    bus_if.free_en   = f;
    bus_if.free_phys = t;
    bus_if.flush     = fl;
    rst              = r;
    @(posedge clk);
    #1;
    model_step(a, c, f, t, fl, r);
    bus_if.alloc_req = 1'b0;
    bus_if.commit_en = 1'b0;
    bus_if.free_en   = 1'b0;
    bus_if.flush     = 1'b0;
    rst              = 1'b0;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 6'd5, 1'b0, 1'b1);
    n_checks++;
    if (bus_if.alloc_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_valid: got %0b expected 1", bus_if.alloc_valid);
    end
    n_checks++;
    if (bus_if.alloc_phys !== 6'(NUM_ARCH)) begin
      n_errors++;
      $display("FAIL reset_phys: got %0d expected %0d", bus_if.alloc_phys, NUM_ARCH);
    end
    n_checks++;
    if (bus_if.free_count !== 6'(DEPTH)) begin
      n_errors++;
      $display("FAIL reset_count: got %0d expected %0d", bus_if.free_count, DEPTH);
    end
    n_checks++;
    if (bus_if.dbg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_err: got %0b expected 0", bus_if.dbg_err);
    end
  endtask

  task automatic test_illegal_ops();
    tick(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1);
    // Commit with nothing allocated, then free into a full queue: both dropped.
    tick(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0);
    n_checks++;
    if (bus_if.free_count !== 6'(DEPTH) || bus_if.alloc_phys !== 6'(NUM_ARCH)) begin
      n_errors++;
      $display("FAIL illegal_drop: got count %0d phys %0d expected %0d %0d",
               bus_if.free_count, bus_if.alloc_phys, DEPTH, NUM_ARCH);
    end
    n_checks++;
    if (bus_if.dbg_err !== CHECK) begin
      n_errors++;
      $display("FAIL illegal_err: got %0b expected %0b", bus_if.dbg_err, CHECK);
    end
  endtask

  task automatic test_alloc_drain();
    tick(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    for (int i = 0; i < int'(DEPTH); i++) begin
      n_checks++;
      if (bus_if.alloc_valid !== 1'b1 || bus_if.alloc_phys !== 6'(NUM_ARCH + i)) begin
        n_errors++;
        $display("FAIL drain_seq[%0d]: got valid %0b phys %0d expected 1 %0d", i,
                 bus_if.alloc_valid, bus_if.alloc_phys, NUM_ARCH + i);
      end
      tick(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    end
    n_checks++;
    if (bus_if.alloc_valid !== 1'b0 || bus_if.free_count !== 6'd0) begin
      n_errors++;
      $display("FAIL drain_empty: got valid %0b count %0d expected 0 0",
               bus_if.alloc_valid, bus_if.free_count);
    end
    tick(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    n_checks++;
    if (bus_if.alloc_valid !== 1'b0 || bus_if.free_count !== 6'd0) begin
      n_errors++;
      $display("FAIL drain_extra: got valid %0b count %0d expected 0 0",
               bus_if.alloc_valid, bus_if.free_count);
    end
  endtask

  task automatic test_flush_recovery();
    tick(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    repeat (5) tick(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
    n_checks++;
    if (bus_if.free_count !== 6'd30 || bus_if.free_count !== 6'(exp_count())) begin
      n_errors++;
      $display("FAIL flush_count: got %0d expected 30", bus_if.free_count);
    end
    n_checks++;
    if (bus_if.alloc_phys !== 6'd34) begin
      n_errors++;
      $display("FAIL flush_phys: got %0d expected 34", bus_if.alloc_phys);
    end
  endtask

  task automatic test_alloc_free_collision();
    tick(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    repeat (DEPTH) tick(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 6'd7, 1'b0, 1'b0);
    n_checks++;
    if (bus_if.alloc_valid !== 1'b1 || bus_if.alloc_phys !== 6'd7) begin
      n_errors++;
      $display("FAIL collide_phys: got valid %0b phys %0d expected 1 7",
               bus_if.alloc_valid, bus_if.alloc_phys);
    end
    n_checks++;
    if (bus_if.free_count !== 6'd1) begin
      n_errors++;
      $display("FAIL collide_count: got %0d expected 1", bus_if.free_count);
    end
  endtask

  // Cycle c: alloc (c<100), commit the previous alloc and free tag c mod 32 (c>=1).
  task automatic test_wrap_triples();
    logic [5:0] want;
    tick(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    for (int c = 0; c <= 100; c++) begin
      if (c < 100) begin
        want = (c < int'(DEPTH)) ? 6'(NUM_ARCH + c) : 6'((c - 31) % 32);
        n_checks++;
        if (bus_if.alloc_valid !== 1'b1 || bus_if.alloc_phys !== want) begin
          n_errors++;
          $display("FAIL wrap_order[%0d]: got valid %0b phys %0d expected 1 %0d", c,
                   bus_if.alloc_valid, bus_if.alloc_phys, want);
        end
      end
      tick(c < 100, c >= 1, c >= 1, 6'(c % 32), 1'b0, 1'b0);
      if (c < 100) begin
        n_checks++;
        if (bus_if.free_count !== 6'd31) begin
          n_errors++;
          $display("FAIL wrap_count[%0d]: got %0d expected 31", c, bus_if.free_count);
        end
      end
    end
  endtask

  task automatic test_flush_commit_free();
    tick(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 6'd9, 1'b1, 1'b0);
    n_checks++;
    if (bus_if.alloc_phys !== 6'd33 || bus_if.free_count !== 6'd32) begin
      n_errors++;
      $display("FAIL fcf_head: got phys %0d count %0d expected 33 32",
               bus_if.alloc_phys, bus_if.free_count);
    end
    repeat (DEPTH - 1) tick(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    n_checks++;
    if (bus_if.alloc_phys !== 6'd9 || bus_if.free_count !== 6'd1) begin
      n_errors++;
      $display("FAIL fcf_tail: got phys %0d count %0d expected 9 1",
               bus_if.alloc_phys, bus_if.free_count);
    end
  endtask

  task automatic test_double_free();
    tick(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    repeat (9) tick(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    repeat (9) tick(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 6'd40, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 6'd40, 1'b0, 1'b0);
    n_checks++;
    if (bus_if.free_count !== (CHECK ? 6'd24 : 6'd25)) begin
      n_errors++;
      $display("FAIL dfree_count: got %0d expected %0d", bus_if.free_count,
               CHECK ? 24 : 25);
    end
    n_checks++;
    if (bus_if.dbg_err !== CHECK) begin
      n_errors++;
      $display("FAIL dfree_err: got %0b expected %0b", bus_if.dbg_err, CHECK);
    end
    tick(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    n_checks++;
    if (bus_if.dbg_err !== 1'b0 || bus_if.free_count !== 6'(DEPTH)) begin
      n_errors++;
      $display("FAIL dfree_rst: got err %0b count %0d expected 0 %0d",
               bus_if.dbg_err, bus_if.free_count, DEPTH);
    end
  endtask

  task automatic test_random();
    bit a, c, f, fl, r;
    tick(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      a  = ($urandom_range(99) < 60);
      c  = ($urandom_range(99) < 45);
      f  = ($urandom_range(99) < 40);
      fl = ($urandom_range(99) < 4);
      r  = ($urandom_range(999) < 3);
      tick(a, c, f, 6'($urandom_range(63)), fl, r);
      n_checks++;
      if (bus_if.alloc_valid !== exp_valid() || bus_if.free_count !== 6'(exp_count())) begin
        n_errors++;
        $display("FAIL rand_state[%0d]: got valid %0b count %0d expected %0b %0d", n,
                 bus_if.alloc_valid, bus_if.free_count, exp_valid(), exp_count());
      end
      if (exp_valid()) begin
        n_checks++;
        if (bus_if.alloc_phys !== exp_phys()) begin
          n_errors++;
          $display("FAIL rand_phys[%0d]: got %0d expected %0d", n, bus_if.alloc_phys,
                   exp_phys());
        end
      end
      n_checks++;
      if (bus_if.dbg_err !== m_err) begin
        n_errors++;
        $display("FAIL rand_err[%0d]: got %0b expected %0b", n, bus_if.dbg_err, m_err);
      end
    end
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    rst              = 1'b1;
    bus_if.alloc_req = 1'b0;
    bus_if.commit_en = 1'b0;
    bus_if.free_en   = 1'b0;
    bus_if.free_phys = '0;
    bus_if.flush     = 1'b0;
    model_reset();
    test_reset();
    test_illegal_ops();
    test_alloc_drain();
    test_flush_recovery();
    test_alloc_free_collision();
    test_wrap_triples();
    test_flush_commit_free();
    test_double_free();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
